// File: rtl/prog_loader.sv
// Instruction store and runtime program loader. Bytes arrive on a slow async strobe
// while load_en is high; the core is held in reset for the whole load.
module prog_loader #(
    parameter int INST_W  = 8,
    parameter int IMEM_SZ = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              strobe,
    input  logic [INST_W-1:0] data_in,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata,
    output logic              cpu_hold,
    output logic              ack,
    output logic [ADDR_W:0]   words,
    output logic              ovf
);

    typedef enum logic [1:0] {RUN, ARM, LOAD, RELEASE} state_t;

    localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(IMEM_SZ);

    logic              load_en_s1, load_en_s2;
    logic              strobe_s1, strobe_s2, strobe_s3;
    logic              stb_edge, wr_en;
    state_t            state;
    logic [ADDR_W-1:0] waddr;
    logic [INST_W-1:0] mem [IMEM_SZ];

    function automatic logic [INST_W-1:0] boot_word(input int idx);
        logic [7:0] b;
        case (idx)
            0:       b = 8'h44;
            1:       b = 8'h0F;
            2:       b = 8'h1E;
            3:       b = 8'h22;
            4:       b = 8'h1F;
            5:       b = 8'h0E;
            6:       b = 8'hF2;
            7:       b = 8'h13;
            default: b = 8'h00;
        endcase
        return INST_W'(b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            load_en_s1 <= 1'b0;
            load_en_s2 <= 1'b0;
            strobe_s1  <= 1'b0;
            strobe_s2  <= 1'b0;
            strobe_s3  <= 1'b0;
        end else begin
            load_en_s1 <= load_en;
            load_en_s2 <= load_en_s1;
            strobe_s1  <= strobe;
            strobe_s2  <= strobe_s1;
            strobe_s3  <= strobe_s2;
        end
    end

    assign stb_edge = strobe_s2 & ~strobe_s3;
    assign wr_en    = (state == LOAD) && stb_edge;

    // Memory has no reset of its own beyond restoring the boot program.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMEM_SZ; i++) mem[i] <= boot_word(i);
        end else if (wr_en) begin
            mem[waddr] <= data_in;
        end
    end

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            waddr    <= '0;
            words    <= '0;
            ovf      <= 1'b0;
            ack      <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                RUN: begin
                    if (load_en_s2) begin
                        state    <= ARM;
                        cpu_hold <= 1'b1;
                    end else begin
                        cpu_hold <= 1'b0;
                    end
                end
                ARM: begin
                    waddr    <= '0;
                    words    <= '0;
                    ovf      <= 1'b0;
                    state    <= LOAD;
                    cpu_hold <= 1'b1;
                end
                LOAD: begin
                    // A byte landing in the same cycle as the load_en drop still counts.
                    if (stb_edge) begin
                        waddr <= waddr + ADDR_W'(1);
                        ack   <= 1'b1;
                        if (words == WORDS_MAX) ovf <= 1'b1;
                        else                    words <= words + (ADDR_W+1)'(1);
                    end
                    if (!load_en_s2) state <= RELEASE;
                    cpu_hold <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a timeline model of load sessions and strobe
// commits is compared every cycle, plus literal checks for the documented scenarios.
module tb_prog_loader;

    logic       clk, rst, load_en, strobe;
    logic [7:0] data_in, rdata;
    logic [3:0] raddr;
    logic       cpu_hold, ack, ovf;
    logic [4:0] words;

    int n_chk = 0;
    int n_fail = 0;

    prog_loader #(.INST_W(8), .IMEM_SZ(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .strobe(strobe), .data_in(data_in),
        .raddr(raddr), .rdata(rdata), .cpu_hold(cpu_hold), .ack(ack), .words(words), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] boot [16] = '{8'h44, 8'h0F, 8'h1E, 8'h22, 8'h1F, 8'h0E, 8'hF2, 8'h13,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Session timeline model: load_en rise sampled at k, fall at f, strobe rise at s.
    // Core held from k+2 until f+3; a byte commits at s+2 if that lies in [k+4, f+2].
    logic [7:0] mmem [16];
    int  cyc = 0;
    int  cnt = 0;
    int  k_s = 0, f_s = 0;
    bit  sess = 0, live = 0;
    bit  p_ld = 0, p_st = 0;
    bit  exp_ack = 0, exp_hold = 0;
    int  pend[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mmem = boot;
            cnt = 0; sess = 0; p_ld = 0; p_st = 0;
            exp_ack = 0; exp_hold = 0; live = 1;
            pend.delete();
        end else begin
            exp_ack = 0;
            if (load_en && !p_ld) begin sess = 1; k_s = cyc; f_s = 1 << 30; end
            if (!load_en && p_ld) f_s = cyc;
            if (strobe && !p_st) pend.push_back(cyc + 2);
            if (sess && cyc == k_s + 3) cnt = 0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                if (sess && cyc >= k_s + 4 && cyc <= f_s + 2) begin
                    mmem[cnt % 16] = data_in;
                    cnt++;
                    exp_ack = 1;
                end
            end
            exp_hold = sess && cyc >= k_s + 2 && cyc < f_s + 3;
            p_ld = load_en;
            p_st = strobe;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
            chk("ack", 32'(ack), 32'(exp_ack));
            chk("words", 32'(words), (cnt > 16) ? 16 : cnt);
            chk("ovf", 32'(ovf), (cnt > 16) ? 1 : 0);
            chk("rdata", 32'(rdata), 32'(mmem[raddr]));
        end
    end

    logic [7:0] img [16];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step(1);
            raddr = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic chk_mem(input string nm);
        for (int a = 0; a < 16; a++) begin
            raddr = 4'(a);
            #1;
            chk(nm, 32'(rdata), 32'(img[a]));
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        data_in = d;
        strobe = 1'b1;
        idle(3 + $urandom_range(0, 2));
        strobe = 1'b0;
        idle(3 + $urandom_range(0, 2));
    endtask

    task automatic load_start();
        load_en = 1'b1;
        idle(4 + $urandom_range(0, 2));
    endtask

    task automatic load_end();
        load_en = 1'b0;
        idle(6);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; strobe = 1'b0; data_in = 8'h00; raddr = 4'h0;
        step(2);
        rst = 1'b0;

        // Reset image
        img = boot;
        chk_mem("boot_image");
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_words", 32'(words), 0);
        chk("rst_ovf", 32'(ovf), 0);
        idle(3);

        // Three-byte load with explicit latency checks on the first byte
        load_start();
        chk("load_hold", 32'(cpu_hold), 1);
        data_in = 8'hA1; strobe = 1'b1; raddr = 4'h0;
        step(1);  chk("lat_ack_k", 32'(ack), 0);
        step(1);  chk("lat_ack_k1", 32'(ack), 0);
        #1;       chk("lat_rdata_pre", 32'(rdata), 32'h44);
        step(1);  chk("lat_ack_k2", 32'(ack), 1);
        #1;       chk("lat_rdata_post", 32'(rdata), 32'hA1);
        step(1);  chk("lat_ack_k3", 32'(ack), 0);
        strobe = 1'b0;
        idle(3);
        send_byte(8'hB2);
        send_byte(8'hC3);
        load_en = 1'b0;
        step(3);  chk("drop_hold_f2", 32'(cpu_hold), 1);
        step(1);  chk("drop_hold_f3", 32'(cpu_hold), 0);
        chk("three_words", 32'(words), 3);
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
        chk_mem("three_mem");
        idle(4);

        // Overflow: 18 bytes 00..11
        load_start();
        for (int i = 0; i < 18; i++) send_byte(8'(i));
        load_end();
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        img[0] = 8'h10; img[1] = 8'h11;
        chk_mem("ovf_mem");
        chk("ovf_words", 32'(words), 16);
        chk("ovf_flag", 32'(ovf), 1);
        load_start();
        chk("ovf_cleared", 32'(ovf), 0);
        chk("words_cleared", 32'(words), 0);
        load_end();

        // Strobes in RUN and in ARM are discarded
        strobe = 1'b1; idle(4); strobe = 1'b0; idle(4);
        load_en = 1'b1;
        step(1);
        strobe = 1'b1; idle(4); strobe = 1'b0; idle(4);
        load_end();
        chk("outside_words", 32'(words), 0);
        chk_mem("outside_mem");

        // Strobe rise and load_en fall sampled on the same edge
        load_start();
        data_in = 8'h5A; strobe = 1'b1; load_en = 1'b0;
        idle(3); strobe = 1'b0; idle(6);
        img[0] = 8'h5A;
        chk("simul_words", 32'(words), 1);
        chk("simul_hold", 32'(cpu_hold), 0);
        chk_mem("simul_mem");

        // Reset in the middle of a load
        load_start();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        rst = 1'b1; load_en = 1'b0; strobe = 1'b0;
        step(2);
        rst = 1'b0;
        img = boot;
        chk("midrst_hold", 32'(cpu_hold), 0);
        chk("midrst_words", 32'(words), 0);
        chk_mem("midrst_mem");
        idle(3);

        // Randomised sessions, checked by the per-cycle model
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                strobe = 1'b1; idle(3); strobe = 1'b0; idle(3);
            end
            load_start();
            for (int b = $urandom_range(0, 20); b > 0; b--) send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 0) begin
                data_in = 8'($urandom_range(0, 255));
                strobe = 1'b1; load_en = 1'b0;
                idle(3); strobe = 1'b0; idle(6);
            end else begin
                load_end();
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
